// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin selection among execution-unit results into a
// single registered CDB transaction (valid/ready toward the ROB).

package expipe_pkg;
    localparam int ROB_IDX_W = 5;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      res_value;
        logic                 exc_valid;
        logic [4:0]           exc_cause;
    } cdb_data_t;
endpackage

module cdb_arbiter #(
    parameter int NUM_EU = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic [NUM_EU-1:0]                 eu_valid_i,
    output logic [NUM_EU-1:0]                 eu_ready_o,
    input  expipe_pkg::cdb_data_t [NUM_EU-1:0] eu_data_i,
    output logic                              cdb_valid_o,
    input  logic                              cdb_ready_i,
    output expipe_pkg::cdb_data_t             cdb_data_o
);
    localparam int PW = $clog2(NUM_EU);
    localparam logic [PW:0]   NUM_EU_W = (PW+1)'(NUM_EU);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_EU - 1);

    logic                  out_valid_q, out_valid_d;
    expipe_pkg::cdb_data_t out_data_q,  out_data_d;
    logic [PW-1:0]         rr_ptr_q,    rr_ptr_d;

    logic          out_free;
    logic          grant_valid;
    logic [PW-1:0] grant_idx;
    logic          accept;

    // Output register is free when empty or being drained this cycle.
    assign out_free = !out_valid_q || cdb_ready_i;

    // Round-robin scan starting at rr_ptr, wrapping modulo NUM_EU.
    always_comb begin
        logic [PW:0] sum;
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        for (int k = 0; k < NUM_EU; k++) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (sum >= NUM_EU_W) sum = sum - NUM_EU_W;
            if (!grant_valid && eu_valid_i[sum[PW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = sum[PW-1:0];
            end
        end
    end

    // rst_ni gates acceptance so nothing is taken while reset is held.
    assign accept = grant_valid && out_free && !flush_i && rst_ni;

    // One-hot ready back to the granted unit.
    for (genvar i = 0; i < NUM_EU; i++) begin : g_ready
        assign eu_ready_o[i] = accept && (grant_idx == PW'(i));
    end

    // Next state: flush beats transfer-in, which beats drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = eu_data_i[grant_idx];
            rr_ptr_d    = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end else if (out_valid_q && cdb_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign cdb_valid_o = out_valid_q;
    assign cdb_data_o  = out_data_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common data bus (CDB) arbiter and driver: collects results from `NUM_EU` execution-unit result ports, selects one per cycle with round-robin priority, and drives a registered CDB transaction toward the commit stage's ROB (`cdb_valid`/`cdb_data`/`cdb_ready`). The registered output is also broadcast to the reservation stations. It is the transmitting end of the CDB protocol that the commit stage receives.

## Interface
- `NUM_EU`, default 4: number of execution-unit result ports; must be ≥ 2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  misprediction flush (from the commit stage `ex_mis_flush_o`).
- `eu_valid_i`  in  `NUM_EU`  result valid, one bit per execution unit.
- `eu_ready_o`  out  `NUM_EU`  result accepted, one bit per execution unit; at most one bit high.
- `eu_data_i`  in  `NUM_EU` × `expipe_pkg::cdb_data_t`  result payload per execution unit (`rob_idx`, `res_value`, exception fields).
- `cdb_valid_o`  out  1  CDB transaction valid.
- `cdb_ready_i`  in  1  ROB accepts the transaction.
- `cdb_data_o`  out  `cdb_data_t`  CDB payload.

## Operation
- State:
  - output register `out_valid` / `out_data`;
  - round-robin pointer `rr_ptr`, width `$clog2(NUM_EU)`.
- `out_free = !out_valid || cdb_ready_i`.
- Grant selection is combinational:
  - Scan indices `rr_ptr, rr_ptr+1, …, NUM_EU-1, 0, …, rr_ptr-1`.
  - The first index `g` with `eu_valid_i[g]` wins.
  - No grant if no input is valid.
- `eu_ready_o[g] = grant_valid && out_free && !flush_i`; all other bits are 0.
- `eu_ready_o` may depend combinationally on `eu_valid_i`. Units must not make `eu_valid_i` depend on `eu_ready_o`.
- Transfer in, when `eu_valid_i[g] && eu_ready_o[g]`:
  - `out_data <= eu_data_i[g]`, `out_valid <= 1`;
  - `rr_ptr <= (g == NUM_EU-1) ? 0 : g+1`.
- Drain, when `cdb_valid_o && cdb_ready_i` with no transfer in the same cycle: `out_valid <= 0`.
- Drain and transfer in the same cycle: the new entry replaces the old one. There is no bubble, so sustained throughput is 1 result/cycle.
- Stall, when `out_valid && !cdb_ready_i`:
  - `out_data` is held stable;
  - `eu_ready_o` is all 0;
  - `rr_ptr` is unchanged.
- Flush has priority over every other event:
  - `out_valid <= 0`;
  - no input is accepted (`eu_ready_o` all 0);
  - `rr_ptr` is unchanged;
  - `cdb_valid_o` is deasserted from the next cycle.
- `rr_ptr` changes only on an accepted transfer.
- Fairness: a continuously valid unit is granted within `NUM_EU` accepted transfers.

## Timing
- Reset values:
  - `cdb_valid_o = 0`;
  - `cdb_data_o = '0`;
  - `rr_ptr = 0`;
  - `eu_ready_o = 0` while `rst_ni` is low.
- Reset asserted mid-operation: the pending CDB entry is discarded immediately (asynchronous). No input is accepted until reset is released.
- Latency: an input accepted in cycle N appears on `cdb_valid_o`/`cdb_data_o` in cycle N+1.
- `cdb_valid_o` and `cdb_data_o` are pure register outputs, with no combinational path from any input.
- Valid/ready rule: once `cdb_valid_o` is asserted, it and `cdb_data_o` stay stable until `cdb_ready_i` is seen high or a flush occurs.
- Idle (no valid inputs and the output register drained): `cdb_valid_o = 0` and the pointer is held.
- Wrap-around: a grant to index `NUM_EU-1` sets `rr_ptr` to 0.

## Test plan
- Reset and single transfer:
  - After reset, `eu_valid_i=4'b0100` with `rob_idx=5`, `res_value=0xDEAD`, `cdb_ready_i=1`.
  - Required: `eu_ready_o=4'b0100` in that cycle; next cycle `cdb_valid_o=1`, `rob_idx=5`, `res_value=0xDEAD`; `rr_ptr=3`.
- Round-robin rotation:
  - `eu_valid_i=4'b1111` held, `cdb_ready_i=1`.
  - Required: grants in order 0,1,2,3,0 on consecutive cycles; `cdb_valid_o` stays high every cycle after the first.
- Backpressure:
  - Output holds `rob_idx=7`, `cdb_ready_i=0` for 3 cycles, `eu_valid_i=4'b0011`.
  - Required: `eu_ready_o=0` and `cdb_data_o` stable for 3 cycles.
  - Then `cdb_ready_i=1`: in the same cycle a grant goes to `rr_ptr`'s next valid unit, and the new data appears the following cycle.
- Wrap-around and skip:
  - `rr_ptr=3` with `eu_valid_i=4'b0010`: grant to 1, then `rr_ptr=2`.
  - Next, `eu_valid_i=4'b0011`: grant to 0 (the scan wraps 2→3→0).
- Flush:
  - `cdb_valid_o=1`, `flush_i=1` while `eu_valid_i=4'b0001`.
  - Required: `eu_ready_o=0`; next cycle `cdb_valid_o=0`; `rr_ptr` unchanged.
  - The cycle after flush deasserts: unit 0 is granted.
- Async reset mid-stall:
  - Assert `rst_ni=0` between clock edges while `cdb_valid_o=1`.
  - Required: `cdb_valid_o=0` and `cdb_data_o=0` immediately, `rr_ptr=0`.
